instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory interface: owns the PC, drives a word-aligned byte address to the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump/flush) and a halt-on-EBREAK state machine.
- Sits between the instruction ROM and the decode stage of the 5-stage Harvard pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset (must be 4-byte aligned).
- IMEM_WORDS, 32, ROM depth in words; fetches at or beyond it are out of range.
- NOP_INSTR, 32'h0000_0013, word presented on o_ifid_instr when the slot is invalid (ADDI x0,x0,0).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_stall  in  1  decode cannot accept; hold PC and IF/ID.
- i_redirect_valid  in  1  branch/jump taken or flush; load new PC.
- i_redirect_pc  in  32  redirect byte address.
- o_imem_addr  out  32  byte address to ROM (= PC register).
- i_imem_instr  in  32  ROM read data, combinational from o_imem_addr.
- o_ifid_valid  out  1  IF/ID holds a real instruction.
- o_ifid_pc  out  32  PC of the IF/ID instruction.
- o_ifid_instr  out  32  IF/ID instruction word.
- o_halted  out  1  fetch unit in HALTED state.
- o_fault  out  1  sticky: an out-of-range fetch was suppressed.

Behaviour:
- Reset: pc_q=RESET_PC, o_ifid_valid=0, o_ifid_pc=0, o_ifid_instr=NOP_INSTR, state=RUN, o_halted=0, o_fault=0. The first ROM read occurs in the cycle after i_rst is sampled low. The first valid IF/ID arrives one edge later.
- o_imem_addr = pc_q, with no registering. ROM latency is zero cycles, so the fetch-to-IF/ID latency is one edge.
- Edge priority: reset > redirect > stall > normal.
- Redirect (any state):
  - pc_q <= {i_redirect_pc[31:2],2'b00}.
  - o_ifid_valid <= 0 and o_ifid_instr <= NOP_INSTR.
  - state <= RUN.
  - Redirect overrides a simultaneous stall.
- Stall without redirect: pc_q and all IF/ID outputs hold.
- Normal advance in RUN, with in-range PC (pc_q[31:2] < IMEM_WORDS):
  - IF/ID <= {1, pc_q, i_imem_instr}.
  - pc_q <= pc_q+4, 32-bit wrapping with no carry-out.
- Out of range in RUN:
  - IF/ID <= {0, pc_q, NOP_INSTR}.
  - o_fault <= 1, cleared only by reset.
  - pc_q holds.
- EBREAK detection: when the word captured in a normal advance equals 32'h0010_0073, it is still registered as valid. On the same edge, state <= HALTED and pc_q holds at the EBREAK address + 4.
- HALTED:
  - o_halted=1.
  - pc_q frozen.
  - Every non-stalled edge writes IF/ID valid=0 (bubbles). The EBREAK already in IF/ID drains normally when decode advances.
  - Only redirect or reset leaves HALTED, to RUN. A redirect handles an older branch that squashes the EBREAK.
- States: RUN, HALTED. No other encodings are reachable; the default arm returns to RUN.
- Reset asserted mid-stall or mid-redirect yields the reset values on that edge regardless of other inputs.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output o_misaligned (1 bit, reset 0).
  - A redirect with i_redirect_pc[1:0]!=0 does not load the PC: pc_q holds, IF/ID is flushed to invalid, o_misaligned <= 1 (sticky until reset), state <= HALTED.
- Not defined: port absent; low bits are silently truncated as above.

Decomposition:
- Package cpu_pkg (shared with decode):
  - EBREAK_INSTR=32'h0010_0073.
  - NOP_INSTR_C=32'h0000_0013.
  - XLEN=32.
  - typedef enum logic {FETCH_RUN, FETCH_HALTED} fetch_state_t.
  - typedef struct packed {logic valid; logic [31:0] pc; logic [31:0] instr;} ifid_t.
- One natural sub-module: fetch_pc_reg (PC register plus next-PC mux: redirect/hold/+4). The IF/ID register and FSM stay in the top.

Test Plan:
- Sequential fetch: reset with ROM words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00000013. The bench must observe:
  - addr 0x0, 0x4, 0x8 on successive cycles.
  - IF/ID valid with pc=0x0/instr=0x00500093 one edge after release.
  - pc=0x4/instr=0x00100113 on the next edge.
- Stall: assert i_stall for 3 cycles at pc=0x8 -> o_imem_addr stays 0x8, IF/ID stays {1,0x4,0x00100113}; on release, IF/ID={1,0x8,...}.
- Redirect beats stall: i_stall=1 and i_redirect_valid=1 with target 0x14 in the same cycle -> next edge pc=0x14 and o_ifid_valid=0. The edge after that gives IF/ID pc=0x14.
- EBREAK halt: word 5 = 0x00100073 -> IF/ID {1,0x14,0x00100073}, o_halted=1, addr frozen at 0x18, following IF/ID valid=0. A redirect to 0x0 then gives o_halted=0 and a fetch from 0x0.
- Out of range: IMEM_WORDS=32 and redirect to 0x80 -> o_ifid_valid=0, o_fault=1, addr stays 0x80. Reset clears o_fault and addr=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x0000_0006 -> o_misaligned=1, o_halted=1, addr unchanged. Without the macro: addr=0x4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch and decode stages.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [31:0] NOP_INSTR_C  = 32'h0000_0013;

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   // Clear the two byte-offset bits so the result is a word address.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection:
// reset value, redirect load, hold, or sequential +4 (wrapping).
module fetch_pc_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   input  logic            hold,
   output logic [XLEN-1:0] pc
);

   // Reset wins, then a redirect load, then hold, otherwise step one word.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc;
      end else if (hold) begin
         pc <= pc;
      end else begin
         pc <= pc + 32'd4;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction ROM and captures its word into the IF/ID register.
// Halts on EBREAK until a redirect or reset.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect to a target that
// is not word aligned is refused and halts fetch with o_misaligned set.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_instr,
   output logic        o_ifid_valid,
   output logic [31:0] o_ifid_pc,
   output logic [31:0] o_ifid_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        o_misaligned,
`endif
   output logic        o_halted,
   output logic        o_fault
);

   localparam logic ST_RUN    = FETCH_RUN;
   localparam logic ST_HALTED = FETCH_HALTED;

   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   logic        state;
   logic [31:0] pc_q;
   ifid_t       ifid_q;
   logic        fault_q;
   logic        in_range;
   logic        misalign_redirect;
   logic        pc_load;
   logic        pc_hold;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misaligned_q;
   assign misalign_redirect = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
`else
   logic        unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
   assign misalign_redirect    = 1'b0;
`endif

   assign in_range = (pc_q[31:2] < IMEM_LIMIT);
   assign pc_load  = i_redirect_valid & ~misalign_redirect;
   assign pc_hold  = i_stall | (state == ST_HALTED) | ~in_range | misalign_redirect;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (i_clk),
      .rst     (i_rst),
      .load    (pc_load),
      .load_pc (word_align(i_redirect_pc)),
      .hold    (pc_hold),
      .pc      (pc_q)
   );

   // IF/ID capture, run/halt state and sticky fault flags; priority is
   // reset, redirect, stall, then the per-state normal behaviour.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ifid_q.valid <= 1'b0;
         ifid_q.pc    <= 32'h0;
         ifid_q.instr <= NOP_INSTR;
         state        <= ST_RUN;
         fault_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else if (i_redirect_valid) begin
         ifid_q.valid <= 1'b0;
         ifid_q.instr <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misalign_redirect) begin
            misaligned_q <= 1'b1;
            state        <= ST_HALTED;
         end else begin
            state        <= ST_RUN;
         end
`else
         state        <= ST_RUN;
`endif
      end else if (!i_stall) begin
         case (state)
            ST_RUN: begin
               if (in_range) begin
                  ifid_q.valid <= 1'b1;
                  ifid_q.pc    <= pc_q;
                  ifid_q.instr <= i_imem_instr;
                  if (i_imem_instr == EBREAK_INSTR) begin
                     state <= ST_HALTED;
                  end
               end else begin
                  ifid_q.valid <= 1'b0;
                  ifid_q.pc    <= pc_q;
                  ifid_q.instr <= NOP_INSTR;
                  fault_q      <= 1'b1;
               end
            end
            ST_HALTED: begin
               ifid_q.valid <= 1'b0;
               ifid_q.instr <= NOP_INSTR;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   assign o_imem_addr  = pc_q;
   assign o_ifid_valid = ifid_q.valid;
   assign o_ifid_pc    = ifid_q.pc;
   assign o_ifid_instr = ifid_q.instr;
   assign o_halted     = (state == ST_HALTED);
   assign o_fault      = fault_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign o_misaligned = misaligned_q;
`endif

endmodule
